datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The module SHALL have parameter BITS, default 8, meaning the width of every data, address and opcode path.
REQ-002 Port i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port i_rst_n  input  1  SHALL be the reset; synchronous, active-low.
REQ-004 Ports i_ld_mar, i_ld_pc, i_ld_acc, i_ld_ir  input  1 each  SHALL be the register load strobes from the control unit.
REQ-005 Port i_ld_mdr  input  1  SHALL be the memory-read request strobe; i_st_acc  input  1  SHALL be the memory-write request strobe.
REQ-006 Ports i_mux_pc_ird, i_mux_ir_p1, i_mux_mdr_alur  input  1 each  SHALL be the mux selects; i_alu_ctrl  input  1  SHALL select the ALU op.
REQ-007 Ports o_opcode  output  BITS  (IR contents), o_acc_zero  output  1  (ACC==0), o_carry  output  1  (ALU carry/borrow flag) SHALL be the status outputs to the control unit.
REQ-008 Port o_busy  output  1  SHALL be high while a memory transaction is outstanding; o_done  output  1  SHALL pulse one cycle on completion.
REQ-009 Ports o_mem_req  output  1, o_mem_we  output  1, o_mem_addr  output  BITS, o_mem_wdata  output  BITS, i_mem_rdata  input  BITS, i_mem_ack  input  1  SHALL form the memory handshake.

Function
REQ-010 Registers PC, MAR, MDR, ACC, IR (BITS each) and carry SHALL be held internally; operand SHALL be IR[BITS-4:0] zero-extended to BITS.
REQ-011 i_ld_mar SHALL load MAR with operand if i_mux_pc_ird=1, else PC, next edge.
REQ-012 i_ld_pc SHALL load PC with operand if i_mux_ir_p1=1, else PC+1 modulo 2^BITS (all-ones wraps to 0).
REQ-013 i_ld_ir SHALL load IR from MDR; o_opcode SHALL equal IR.
REQ-014 ALU SHALL compute ACC+MDR (i_alu_ctrl=0) or ACC-MDR (i_alu_ctrl=1) modulo 2^BITS; carry = carry-out on add, borrow (ACC<MDR) on sub.
REQ-015 i_ld_acc SHALL load ACC from ALU result if i_mux_mdr_alur=1 (and update carry), else from MDR (carry unchanged).
REQ-016 o_acc_zero SHALL be combinational from the ACC register, not from the ALU.
REQ-017 Memory FSM SHALL have states IDLE, RD_WAIT, WR_WAIT.
REQ-018 IDLE + i_ld_mdr -> RD_WAIT next edge; o_mem_req=1, o_mem_we=0, o_mem_addr latched from MAR at that edge.
REQ-019 IDLE + i_st_acc (i_ld_mdr=0) -> WR_WAIT; o_mem_req=1, o_mem_we=1, o_mem_addr latched from MAR, o_mem_wdata latched from ACC.
REQ-020 i_ld_mdr and i_st_acc together in IDLE SHALL start a read only; the write SHALL be dropped.
REQ-021 RD_WAIT + i_mem_ack -> IDLE; MDR <= i_mem_rdata, o_mem_req drops, o_done=1 for the following cycle.
REQ-022 WR_WAIT + i_mem_ack -> IDLE; o_mem_req drops, o_done=1 for the following cycle; MDR unchanged.
REQ-023 o_busy SHALL equal (state != IDLE); minimum transaction is 2 cycles (req edge, ack edge); no timeout; wait indefinitely.
REQ-024 i_ld_mdr/i_st_acc while busy SHALL be ignored (not queued); i_mem_ack in IDLE SHALL be ignored.
REQ-025 MAR/ACC loads during a transaction SHALL apply but SHALL NOT alter latched o_mem_addr/o_mem_wdata.
REQ-026 Multiple strobes in one cycle SHALL all take effect, each using pre-edge register values.

Reset
REQ-027 i_rst_n=0 at an edge SHALL clear PC, MAR, MDR, ACC, IR, carry, latched addr/wdata to 0, FSM to IDLE; o_mem_req, o_mem_we, o_busy, o_done = 0.
REQ-028 Reset during RD_WAIT/WR_WAIT SHALL abandon the transaction; o_mem_req low the next cycle; a coincident ack SHALL NOT load MDR.
REQ-029 After reset o_acc_zero SHALL be 1.

Verification
REQ-030 Reset, then i_ld_pc with i_mux_ir_p1=0 for 256 cycles (BITS=8) -> PC counts 1..255 then 0.
REQ-031 MAR=0x10, i_ld_mdr, ack after 3 cycles with rdata=0xA5 -> o_mem_addr=0x10, o_busy 3 cycles, MDR=0xA5, o_done one cycle.
REQ-032 ACC=0xF0, MDR=0x20, ADD with i_mux_mdr_alur=1 -> ACC=0x10, carry=1; then SUB MDR=0x10 -> ACC=0x00, carry=0, o_acc_zero=1.
REQ-033 i_ld_mdr and i_st_acc same cycle, then i_st_acc while busy -> one read only, o_mem_we=0, second request ignored.
REQ-034 ACC=0x3C, i_st_acc, then i_ld_acc changing ACC to 0x00 before ack -> o_mem_wdata stays 0x3C until ack.
REQ-035 i_rst_n=0 in RD_WAIT coincident with ack rdata=0x77 -> MDR=0, o_mem_req=0, o_done=0 next cycle.

Source files
------------

// File: rtl/datapath_if.sv
// Memory handshake bundle between the datapath (master) and the memory (slave).
interface datapath_if #(parameter int BITS = 8);
    logic            o_mem_req;
    logic            o_mem_we;
    logic [BITS-1:0] o_mem_addr;
    logic [BITS-1:0] o_mem_wdata;
    logic [BITS-1:0] i_mem_rdata;
    logic            i_mem_ack;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata, i_mem_ack
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata, i_mem_ack
    );
endinterface

// File: rtl/datapath.sv
// Accumulator-machine datapath: PC/MAR/MDR/ACC/IR registers, add/sub ALU and a
// three-state memory handshake FSM with latched address and write data.
module datapath #(
    parameter int BITS = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ld_mar,
    input  logic            i_ld_pc,
    input  logic            i_ld_acc,
    input  logic            i_ld_ir,
    input  logic            i_ld_mdr,
    input  logic            i_st_acc,
    input  logic            i_mux_pc_ird,
    input  logic            i_mux_ir_p1,
    input  logic            i_mux_mdr_alur,
    input  logic            i_alu_ctrl,
    output logic [BITS-1:0] o_opcode,
    output logic            o_acc_zero,
    output logic            o_carry,
    output logic            o_busy,
    output logic            o_done,
    datapath_if.master      mem
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t          state_reg;
    logic [BITS-1:0] pc_reg;
    logic [BITS-1:0] mar_reg;
    logic [BITS-1:0] mdr_reg;
    logic [BITS-1:0] acc_reg;
    logic [BITS-1:0] ir_reg;
    logic            carry_reg;
    logic            req_reg;
    logic            we_reg;
    logic            done_reg;
    logic [BITS-1:0] addr_reg;
    logic [BITS-1:0] wdata_reg;

    logic [BITS-1:0] operand;
    logic [BITS:0]   alu_full;

    // Top bit of the widened difference is the borrow, so one expression serves both ops.
    assign operand  = {{3{1'b0}}, ir_reg[BITS-4:0]};
    assign alu_full = i_alu_ctrl ? ({1'b0, acc_reg} - {1'b0, mdr_reg})
                                 : ({1'b0, acc_reg} + {1'b0, mdr_reg});

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            mar_reg   <= '0;
            mdr_reg   <= '0;
            acc_reg   <= '0;
            ir_reg    <= '0;
            carry_reg <= 1'b0;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            done_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            if (i_ld_mar)
                mar_reg <= i_mux_pc_ird ? operand : pc_reg;
            if (i_ld_pc)
                pc_reg <= i_mux_ir_p1 ? operand : pc_reg + BITS'(1);
            if (i_ld_ir)
                ir_reg <= mdr_reg;
            if (i_ld_acc) begin
                if (i_mux_mdr_alur) begin
                    acc_reg   <= alu_full[BITS-1:0];
                    carry_reg <= alu_full[BITS];
                end else begin
                    acc_reg <= mdr_reg;
                end
            end

            done_reg <= 1'b0;
            // Requests while busy are dropped; a read wins over a simultaneous write.
            unique case (state_reg)
                IDLE: begin
                    if (i_ld_mdr) begin
                        state_reg <= RD_WAIT;
                        req_reg   <= 1'b1;
                        we_reg    <= 1'b0;
                        addr_reg  <= mar_reg;
                    end else if (i_st_acc) begin
                        state_reg <= WR_WAIT;
                        req_reg   <= 1'b1;
                        we_reg    <= 1'b1;
                        addr_reg  <= mar_reg;
                        wdata_reg <= acc_reg;
                    end
                end
                RD_WAIT: begin
                    if (mem.i_mem_ack) begin
                        mdr_reg   <= mem.i_mem_rdata;
                        state_reg <= IDLE;
                        req_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (mem.i_mem_ack) begin
                        state_reg <= IDLE;
                        req_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_opcode        = ir_reg;
    assign o_acc_zero      = (acc_reg == '0);
    assign o_carry         = carry_reg;
    assign o_busy          = (state_reg != IDLE);
    assign o_done          = done_reg;
    assign mem.o_mem_req   = req_reg;
    assign mem.o_mem_we    = we_reg;
    assign mem.o_mem_addr  = addr_reg;
    assign mem.o_mem_wdata = wdata_reg;

endmodule

// File: tb/tb_datapath.sv
// Directed and randomized checks of datapath against a cycle-level behavioural model.
module tb_datapath;

    localparam int BITS = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic ld_mar, ld_pc, ld_acc, ld_ir, ld_mdr, st_acc;
    logic mux_pc_ird, mux_ir_p1, mux_mdr_alur, alu_ctrl;
    logic [BITS-1:0] opcode;
    logic acc_zero, carry, busy, done;

    datapath_if #(.BITS(BITS)) bus ();

    datapath #(.BITS(BITS)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_ld_mar       (ld_mar),
        .i_ld_pc        (ld_pc),
        .i_ld_acc       (ld_acc),
        .i_ld_ir        (ld_ir),
        .i_ld_mdr       (ld_mdr),
        .i_st_acc       (st_acc),
        .i_mux_pc_ird   (mux_pc_ird),
        .i_mux_ir_p1    (mux_ir_p1),
        .i_mux_mdr_alur (mux_mdr_alur),
        .i_alu_ctrl     (alu_ctrl),
        .o_opcode       (opcode),
        .o_acc_zero     (acc_zero),
        .o_carry        (carry),
        .o_busy         (busy),
        .o_done         (done),
        .mem            (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state (plain integers, values 0..255)
    int  m_pc, m_mar, m_mdr, m_acc, m_ir, m_addr, m_wdata;
    bit  m_carry, m_busy, m_wr, m_done;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic clear_strobes();
        ld_mar = 0; ld_pc = 0; ld_acc = 0; ld_ir = 0; ld_mdr = 0; st_acc = 0;
        mux_pc_ird = 0; mux_ir_p1 = 0; mux_mdr_alur = 0; alu_ctrl = 0;
    endtask

    task automatic check_all();
        check("opcode",    32'(opcode),           32'(m_ir));
        check("acc_zero",  32'(acc_zero),         32'(m_acc == 0));
        check("carry",     32'(carry),            32'(m_carry));
        check("busy",      32'(busy),             32'(m_busy));
        check("done",      32'(done),             32'(m_done));
        check("mem_req",   32'(bus.o_mem_req),    32'(m_busy));
        check("mem_we",    32'(bus.o_mem_we),     32'(m_busy && m_wr));
        check("mem_addr",  32'(bus.o_mem_addr),   32'(m_addr));
        check("mem_wdata", 32'(bus.o_mem_wdata),  32'(m_wdata));
        check("pc",        32'(dut.pc_reg),       32'(m_pc));
        check("mar",       32'(dut.mar_reg),      32'(m_mar));
        check("mdr",       32'(dut.mdr_reg),      32'(m_mdr));
        check("acc",       32'(dut.acc_reg),      32'(m_acc));
    endtask

    // One clock: predict from current inputs, clock the DUT, then compare.
    task automatic tick();
        int n_pc, n_mar, n_mdr, n_acc, n_ir, n_addr, n_wdata, operand, sum;
        bit n_carry, n_busy, n_wr, n_done;
        n_pc = m_pc; n_mar = m_mar; n_mdr = m_mdr; n_acc = m_acc; n_ir = m_ir;
        n_addr = m_addr; n_wdata = m_wdata; n_carry = m_carry;
        n_busy = m_busy; n_wr = m_wr; n_done = 0;
        if (!rst_n) begin
            n_pc = 0; n_mar = 0; n_mdr = 0; n_acc = 0; n_ir = 0;
            n_addr = 0; n_wdata = 0; n_carry = 0; n_busy = 0; n_wr = 0;
        end else begin
            operand = m_ir % 32;
            if (ld_mar) n_mar = mux_pc_ird ? operand : m_pc;
            if (ld_pc)  n_pc  = mux_ir_p1 ? operand : (m_pc + 1) % 256;
            if (ld_ir)  n_ir  = m_mdr;
            if (ld_acc) begin
                if (!mux_mdr_alur) n_acc = m_mdr;
                else if (!alu_ctrl) begin
                    sum = m_acc + m_mdr;
                    n_acc = sum % 256;
                    n_carry = (sum > 255);
                end else begin
                    n_acc = (m_acc - m_mdr + 256) % 256;
                    n_carry = (m_acc < m_mdr);
                end
            end
            if (!m_busy) begin
                if (ld_mdr || st_acc) begin
                    n_busy = 1;
                    n_wr = !ld_mdr;
                    n_addr = m_mar;
                    if (!ld_mdr) n_wdata = m_acc;
                end
            end else if (bus.i_mem_ack) begin
                if (!m_wr) n_mdr = int'(bus.i_mem_rdata);
                n_busy = 0;
                n_done = 1;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_mar = n_mar; m_mdr = n_mdr; m_acc = n_acc; m_ir = n_ir;
        m_addr = n_addr; m_wdata = n_wdata; m_carry = n_carry;
        m_busy = n_busy; m_wr = n_wr; m_done = n_done;
        check_all();
    endtask

    // Issue a read or write, hold ack off for wait_cycles-1 cycles, then ack.
    task automatic mem_txn(input bit wr, input int wait_cycles, input int rdata, output int busy_cnt);
        clear_strobes();
        if (wr) st_acc = 1; else ld_mdr = 1;
        tick();
        clear_strobes();
        busy_cnt = int'(busy);
        for (int k = 1; k < wait_cycles; k++) begin
            tick();
            busy_cnt += int'(busy);
        end
        bus.i_mem_ack = 1; bus.i_mem_rdata = rdata[BITS-1:0];
        tick();
        bus.i_mem_ack = 0;
        $display("txn %s wait=%0d rdata=0x%0h busy_cycles=%0d done=%0b", wr ? "WR" : "RD",
                 wait_cycles, rdata, busy_cnt, done);
    endtask

    task automatic set_acc(input int v);
        int b;
        mem_txn(0, 1, v, b);
        ld_acc = 1; mux_mdr_alur = 0;
        tick();
        clear_strobes();
    endtask

    initial begin
        int b;
        m_pc = 0; m_mar = 0; m_mdr = 0; m_acc = 0; m_ir = 0; m_addr = 0; m_wdata = 0;
        m_carry = 0; m_busy = 0; m_wr = 0; m_done = 0;
        clear_strobes();
        bus.i_mem_ack = 0; bus.i_mem_rdata = '0;
        rst_n = 0;
        #1;
        tick();
        tick();
        check("rst_acc_zero", 32'(acc_zero), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1;

        // PC increment and wrap
        ld_pc = 1;
        for (int i = 1; i <= 256; i++) begin
            tick();
            check("pc_count", 32'(dut.pc_reg), 32'(i % 256));
        end
        $display("pc sweep complete pc=0x%0h", dut.pc_reg);
        clear_strobes();

        // MAR = 0x10 via IR operand, then read with 3-cycle wait
        mem_txn(0, 1, 'h10, b);
        ld_ir = 1; tick(); clear_strobes();
        ld_mar = 1; mux_pc_ird = 1; tick(); clear_strobes();
        check("mar_10", 32'(dut.mar_reg), 32'h10);
        mem_txn(0, 3, 'hA5, b);
        check("rd_busy_cycles", 32'(b), 32'd3);
        check("rd_addr", 32'(bus.o_mem_addr), 32'h10);
        check("rd_mdr", 32'(dut.mdr_reg), 32'hA5);
        check("rd_done", 32'(done), 32'd1);
        tick();
        check("rd_done_pulse", 32'(done), 32'd0);

        // ALU add with carry, then subtract to zero
        set_acc('hF0);
        mem_txn(0, 1, 'h20, b);
        ld_acc = 1; mux_mdr_alur = 1; alu_ctrl = 0; tick(); clear_strobes();
        check("add_acc", 32'(dut.acc_reg), 32'h10);
        check("add_carry", 32'(carry), 32'd1);
        mem_txn(0, 1, 'h10, b);
        ld_acc = 1; mux_mdr_alur = 1; alu_ctrl = 1; tick(); clear_strobes();
        check("sub_acc", 32'(dut.acc_reg), 32'h00);
        check("sub_carry", 32'(carry), 32'd0);
        check("sub_zero", 32'(acc_zero), 32'd1);
        $display("alu add/sub acc=0x%0h carry=%0b", dut.acc_reg, carry);

        // Simultaneous read+write, then write while busy
        ld_mdr = 1; st_acc = 1; tick(); clear_strobes();
        check("rw_we", 32'(bus.o_mem_we), 32'd0);
        st_acc = 1; tick(); clear_strobes();
        bus.i_mem_ack = 1; bus.i_mem_rdata = 8'h5A; tick(); bus.i_mem_ack = 0;
        check("rw_mdr", 32'(dut.mdr_reg), 32'h5A);
        tick();
        check("rw_no_queue", 32'(bus.o_mem_req), 32'd0);
        $display("read+write collision resolved as read mdr=0x%0h", dut.mdr_reg);

        // Write data latched despite ACC change mid-transaction
        set_acc('h3C);
        st_acc = 1; tick(); clear_strobes();
        ld_acc = 1; mux_mdr_alur = 1; alu_ctrl = 1; tick(); clear_strobes();
        check("wr_acc_now", 32'(dut.acc_reg), 32'h00);
        tick();
        check("wr_wdata_held", 32'(bus.o_mem_wdata), 32'h3C);
        check("wr_we", 32'(bus.o_mem_we), 32'd1);
        bus.i_mem_ack = 1; tick(); bus.i_mem_ack = 0;
        check("wr_wdata_final", 32'(bus.o_mem_wdata), 32'h3C);
        check("wr_done", 32'(done), 32'd1);
        $display("write wdata=0x%0h held across acc change", bus.o_mem_wdata);

        // Reset during RD_WAIT with coincident ack
        ld_mdr = 1; tick(); clear_strobes();
        tick();
        rst_n = 0; bus.i_mem_ack = 1; bus.i_mem_rdata = 8'h77; tick();
        rst_n = 1; bus.i_mem_ack = 0;
        check("rst_rd_mdr", 32'(dut.mdr_reg), 32'h00);
        check("rst_rd_req", 32'(bus.o_mem_req), 32'd0);
        check("rst_rd_done", 32'(done), 32'd0);
        $display("reset abandoned read mdr=0x%0h", dut.mdr_reg);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 63) != 0);
            ld_mar       = 1'($urandom_range(0, 1));
            ld_pc        = 1'($urandom_range(0, 1));
            ld_acc       = 1'($urandom_range(0, 1));
            ld_ir        = 1'($urandom_range(0, 1));
            ld_mdr       = ($urandom_range(0, 3) == 0);
            st_acc       = ($urandom_range(0, 3) == 0);
            mux_pc_ird   = 1'($urandom_range(0, 1));
            mux_ir_p1    = 1'($urandom_range(0, 1));
            mux_mdr_alur = 1'($urandom_range(0, 1));
            alu_ctrl     = 1'($urandom_range(0, 1));
            bus.i_mem_ack   = ($urandom_range(0, 2) == 0);
            bus.i_mem_rdata = 8'($urandom);
            tick();
        end
        rst_n = 1;
        clear_strobes();
        bus.i_mem_ack = 0;
        $display("random phase complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
